// File: rtl/configurable_demux_pkg.sv
// configurable_demux_pkg: shared defaults and helpers for the
// registered 1-to-N demultiplexer.
// Contents: DEMUX_SEL_WIDTH_DEF, DEMUX_DATA_WIDTH_DEF, lanes().
package configurable_demux_pkg;

   localparam int DEMUX_SEL_WIDTH_DEF  = 2;
   localparam int DEMUX_DATA_WIDTH_DEF = 32;

   // Number of output lanes addressed by a select of sel_width bits.
   function automatic int lanes(input int sel_width);
      return 1 << sel_width;
   endfunction

endpackage

// File: rtl/demux_onehot_decoder.sv
// demux_onehot_decoder: combinational select -> one-hot decoder.
// Ports: sel_i (lane index), en_i (enable), onehot_o (N bits,
// all zero when en_i is low).
module demux_onehot_decoder
   import configurable_demux_pkg::*;
#(
   parameter int SEL_WIDTH = DEMUX_SEL_WIDTH_DEF
) (
   input  logic [SEL_WIDTH-1:0]        sel_i,
   input  logic                        en_i,
   output logic [lanes(SEL_WIDTH)-1:0] onehot_o
);

   always_comb begin
      onehot_o = '0;
      if (en_i) begin
         // sel_i spans exactly N lanes, so every index is in range.
         onehot_o[sel_i] = 1'b1;
      end
   end

endmodule

// File: rtl/configurable_demux.sv
// configurable_demux: registered 1-to-2**SEL_WIDTH demultiplexer.
// Ports: clk_i, rst_i (async, active high), data_i, sel_i,
// valid_i in; data_o (N lanes), valid_o (one-hot) out.
// Macro CONFIGURABLE_DEMUX_HOLD_EN: unselected lanes keep
// their last value instead of clearing to zero.
module configurable_demux
   import configurable_demux_pkg::*;
#(
   parameter int SEL_WIDTH  = DEMUX_SEL_WIDTH_DEF,
   parameter int DATA_WIDTH = DEMUX_DATA_WIDTH_DEF
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [DATA_WIDTH-1:0]       data_i,
   input  logic [SEL_WIDTH-1:0]        sel_i,
   input  logic                        valid_i,
   output logic [lanes(SEL_WIDTH)-1:0]
                [DATA_WIDTH-1:0]       data_o,
   output logic [lanes(SEL_WIDTH)-1:0] valid_o
);

   localparam int N = lanes(SEL_WIDTH);

   logic [N-1:0]                 hit;
   logic [N-1:0][DATA_WIDTH-1:0] lane_q;
   logic [N-1:0]                 valid_q;

   // One decode drives both the lane write enables and valid_o,
   // so the two can never disagree.
   demux_onehot_decoder #(
      .SEL_WIDTH (SEL_WIDTH)
   ) u_dec (
      .sel_i    (sel_i),
      .en_i     (valid_i),
      .onehot_o (hit)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lane_q  <= '0;
         valid_q <= '0;
      end else begin
         valid_q <= hit;
         for (int k = 0; k < N; k++) begin
            if (hit[k]) begin
               lane_q[k] <= data_i;
            end else begin
`ifdef CONFIGURABLE_DEMUX_HOLD_EN
               lane_q[k] <= lane_q[k];
`else
               lane_q[k] <= '0;
`endif
            end
         end
      end
   end

   assign data_o  = lane_q;
   assign valid_o = valid_q;

`ifndef SYNTHESIS
   // An unknown select on a valid transfer is a caller bug.
   sel_known_a : assert property (
      @(posedge clk_i) disable iff (rst_i)
      valid_i |-> !$isunknown(sel_i)
   ) else $error("sel_i unknown while valid_i high");
`endif

endmodule

// File: tb/tb_configurable_demux.sv
// tb_configurable_demux: scoreboard bench for configurable_demux
// at SEL_WIDTH 2/32-bit, plus 1/8-bit and 3/8-bit sweeps.
module tb_configurable_demux;

`ifdef CONFIGURABLE_DEMUX_HOLD_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   typedef struct {
      int              id;
      logic [7:0]      v;
      logic [255:0]    d;
      string           name;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk_i = ~clk_i;

   // DUT 0: SEL_WIDTH 2, DATA_WIDTH 32
   logic [31:0]      di0 = '0;
   logic [1:0]       s0  = '0;
   logic             vi0 = 1'b0;
   logic [3:0][31:0] d0;
   logic [3:0]       v0;
   // DUT 1: SEL_WIDTH 1, DATA_WIDTH 8
   logic [7:0]       di1 = '0;
   logic [0:0]       s1  = '0;
   logic             vi1 = 1'b0;
   logic [1:0][7:0]  d1;
   logic [1:0]       v1;
   // DUT 2: SEL_WIDTH 3, DATA_WIDTH 8
   logic [7:0]       di2 = '0;
   logic [2:0]       s2  = '0;
   logic             vi2 = 1'b0;
   logic [7:0][7:0]  d2;
   logic [7:0]       v2;

   configurable_demux #(.SEL_WIDTH(2), .DATA_WIDTH(32)) u0 (
      .clk_i(clk_i), .rst_i(rst_i), .data_i(di0), .sel_i(s0),
      .valid_i(vi0), .data_o(d0), .valid_o(v0));
   configurable_demux #(.SEL_WIDTH(1), .DATA_WIDTH(8)) u1 (
      .clk_i(clk_i), .rst_i(rst_i), .data_i(di1), .sel_i(s1),
      .valid_i(vi1), .data_o(d1), .valid_o(v1));
   configurable_demux #(.SEL_WIDTH(3), .DATA_WIDTH(8)) u2 (
      .clk_i(clk_i), .rst_i(rst_i), .data_i(di2), .sel_i(s2),
      .valid_i(vi2), .data_o(d2), .valid_o(v2));

   // Lane k of any DUT lands in bits [32k+31:32k], zero-extended.
   function automatic logic [255:0] act_d(input int id);
      logic [255:0] r;
      r = '0;
      for (int k = 0; k < 8; k++) begin
         if (id == 0 && k < 4) r[k*32 +: 32] = d0[k];
         if (id == 1 && k < 2) r[k*32 +: 32] = {24'h0, d1[k]};
         if (id == 2)          r[k*32 +: 32] = {24'h0, d2[k]};
      end
      return r;
   endfunction

   function automatic logic [7:0] act_v(input int id);
      if (id == 0) return {4'h0, v0};
      if (id == 1) return {6'h0, v1};
      return v2;
   endfunction

   task automatic chk(input string nm, input logic [255:0] act,
                      input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, act, exp);
      end
   endtask

   // Monitor: pops every expectation due at this negedge.
   always @(negedge clk_i) begin
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk({e.name, ".valid"}, 256'(act_v(e.id)), 256'(e.v));
         chk({e.name, ".data"}, act_d(e.id), e.d);
      end
   end

   function automatic logic [255:0] pack4(input logic [31:0] l0,
      input logic [31:0] l1, input logic [31:0] l2,
      input logic [31:0] l3);
      return {128'h0, l3, l2, l1, l0};
   endfunction

   task automatic step(input int id, input logic vin,
                       input int sel, input logic [31:0] data,
                       input logic [7:0] ev, input logic [255:0] ed,
                       input string nm);
      exp_t e;
      @(negedge clk_i);
      #1;
      vi0 = 1'b0; vi1 = 1'b0; vi2 = 1'b0;
      case (id)
         0: begin vi0 = vin; s0 = 2'(sel); di0 = data; end
         1: begin vi1 = vin; s1 = 1'(sel); di1 = data[7:0]; end
         default: begin vi2 = vin; s2 = 3'(sel); di2 = data[7:0]; end
      endcase
      e.id = id; e.v = ev; e.d = ed; e.name = nm;
      q.push_back(e);
   endtask

   localparam logic [31:0] A = 32'h12345678;
   localparam logic [31:0] B = 32'hfedcba98;

   initial begin
      logic [31:0] h;
      logic [255:0] ed;
      int wait_n;
      #2;
      chk("reset_init.valid", 256'(act_v(0)), '0);
      chk("reset_init.data", act_d(0), '0);
      @(negedge clk_i);
      #1 rst_i = 1'b0;

      h = HOLD ? A : 32'h0;
      step(0, 1'b1, 0, A, 8'h01, pack4(A, 0, 0, 0), "lane0");
      step(0, 1'b1, 1, A, 8'h02, pack4(h, A, 0, 0), "lane1");
      step(0, 1'b1, 2, B, 8'h04,
           pack4(h, h, B, 0), "lane2");
      step(0, 1'b1, 3, B, 8'h08,
           pack4(h, h, HOLD ? B : 0, B), "lane3");
      step(0, 1'b0, 0, 32'hdeadbeef, 8'h00,
           HOLD ? pack4(A, A, B, B) : '0, "idle");
      step(0, 1'b1, 1, 32'h11111111, 8'h02,
           pack4(h, 32'h11111111, HOLD ? B : 0, HOLD ? B : 0),
           "same1a");
      step(0, 1'b1, 1, 32'h22222222, 8'h02,
           pack4(h, 32'h22222222, HOLD ? B : 0, HOLD ? B : 0),
           "same1b");

      // Mid-run reset with lanes loaded: must clear with no edge.
      @(negedge clk_i);
      #1;
      vi0 = 1'b1; s0 = 2'd0; di0 = 32'hffffffff;
      rst_i = 1'b1;
      #1;
      chk("reset_mid.valid", 256'(act_v(0)), '0);
      chk("reset_mid.data", act_d(0), '0);
      @(negedge clk_i);
      chk("reset_hold.valid", 256'(act_v(0)), '0);
      chk("reset_hold.data", act_d(0), '0);
      #1;
      vi0 = 1'b0;
      rst_i = 1'b0;
      step(0, 1'b1, 2, 32'hcafef00d, 8'h04,
           pack4(0, 0, 32'hcafef00d, 0), "post_reset");

      // Sweep SEL_WIDTH=1: lanes at or below k carry A5 under hold.
      for (int k = 0; k < 2; k++) begin
         ed = '0;
         for (int j = 0; j <= k; j++)
            if (j == k || HOLD) ed[j*32 +: 32] = 32'h000000a5;
         step(1, 1'b1, k, 32'h000000a5, 8'(1 << k), ed,
              $sformatf("sw1_k%0d", k));
      end
      step(1, 1'b0, 0, 32'h0, 8'h00,
           HOLD ? {192'h0, 32'ha5, 32'ha5} : '0, "sw1_idle");

      // Sweep SEL_WIDTH=3.
      for (int k = 0; k < 8; k++) begin
         ed = '0;
         for (int j = 0; j <= k; j++)
            if (j == k || HOLD) ed[j*32 +: 32] = 32'h000000a5;
         step(2, 1'b1, k, 32'h000000a5, 8'(1 << k), ed,
              $sformatf("sw3_k%0d", k));
      end

      // Drain the scoreboard within a bounded number of cycles.
      wait_n = 0;
      @(negedge clk_i);
      while (q.size() > 0 && wait_n < 8) begin
         @(negedge clk_i);
         wait_n++;
      end
      #1;
      if (q.size() > 0) begin
         failures++;
         $display("FAIL drain left=%0d exp=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
